// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - ID-stage branch sequencing bus between pipeline and branch_ctrl
interface branch_ctrl_if;
  logic        id_valid;
  logic [2:0]  id_branch_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_target;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_memread;
  logic [4:0]  mem_rd;
  logic        cmp_zero;
  logic [2:0]  br_op;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        flush_ifid;
  logic        flush_idex;

  modport master (
    output id_valid, id_branch_op, id_rs, id_rt, id_target,
    output ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd, cmp_zero,
    input  br_op, stall, pc_redirect, redirect_target, flush_ifid, flush_idex
  );

  modport slave (
    input  id_valid, id_branch_op, id_rs, id_rt, id_target,
    input  ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd, cmp_zero,
    output br_op, stall, pc_redirect, redirect_target, flush_ifid, flush_idex
  );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage branch stall/resolve sequencer with redirect and statistics
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  branch_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [2:0]  op_q, op_q_nx;
  logic        is_br, uses_rt, hit_ex, hit_mem, resolve, taken;
  logic [1:0]  need;

  // ID holds a wrong-path instruction during the redirect pulse, and nothing starts under reset
  always_comb begin
    is_br   = reset & bus.id_valid & ~bus.pc_redirect &
              (bus.id_branch_op >= 3'd1) & (bus.id_branch_op <= 3'd5);
    uses_rt = (bus.id_branch_op == 3'd1) | (bus.id_branch_op == 3'd2);
    hit_ex  = (bus.ex_rd != 5'd0) &
              ((bus.ex_rd == bus.id_rs) | (uses_rt & (bus.ex_rd == bus.id_rt)));
    hit_mem = (bus.mem_rd != 5'd0) &
              ((bus.mem_rd == bus.id_rs) | (uses_rt & (bus.mem_rd == bus.id_rt)));
    if (bus.ex_regwrite & bus.ex_memread & hit_ex)
      need = 2'd2;
    else if ((bus.ex_regwrite & hit_ex) | (bus.mem_memread & hit_mem))
      need = 2'd1;
    else
      need = 2'd0;
  end

  // cnt holds the stall cycles still owed after the current one
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    op_q_nx   = op_q;
    bus.stall = 1'b0;
    bus.br_op = 3'd0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        if (is_br) begin
          if (need == 2'd0) begin
            bus.br_op = bus.id_branch_op;
            resolve   = 1'b1;
          end else begin
            bus.stall = 1'b1;
            op_q_nx   = bus.id_branch_op;
            cnt_nx    = need - 2'd1;
            state_nx  = (need == 2'd1) ? RESOLVE : WAIT;
          end
        end
      end
      WAIT: begin
        bus.stall = 1'b1;
        cnt_nx    = cnt - 2'd1;
        if (!bus.id_valid)
          state_nx = IDLE;
        else if (cnt == 2'd1)
          state_nx = RESOLVE;
      end
      RESOLVE: begin
        bus.br_op = op_q;
        resolve   = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign taken = resolve & bus.cmp_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cnt                 <= 2'd0;
      op_q                <= 3'd0;
      bus.pc_redirect     <= 1'b0;
      bus.flush_ifid      <= 1'b0;
      bus.flush_idex      <= 1'b0;
      bus.redirect_target <= 32'd0;
      stat_branches       <= '0;
      stat_taken          <= '0;
      stat_stall_cycles   <= '0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      op_q            <= op_q_nx;
      bus.pc_redirect <= taken;
      bus.flush_ifid  <= taken;
      bus.flush_idex  <= taken;
      if (taken)
        bus.redirect_target <= bus.id_target;
      if (resolve && !(&stat_branches))
        stat_branches <= stat_branches + CNT_W'(1);
      if (taken && !(&stat_taken))
        stat_taken <= stat_taken + CNT_W'(1);
      if (bus.stall && !(&stat_stall_cycles))
        stat_stall_cycles <= stat_stall_cycles + CNT_W'(1);
    end
  end

endmodule
